// File: rtl/isa_cycle_engine.sv
`default_nettype none
// ============================================================================
// Module : isa_cycle_engine
// Brief  : Turns one latched Zorro II access into ISA-style VGA bus cycles
//          (BALE, MEMR/MEMW/IOR/IOW, SA0/SA12) and returns data plus an ack.
// Rev    : 1.0  initial release
// ============================================================================
module isa_cycle_engine #(
  parameter int SETUP_CLKS   = 2,
  parameter int STROBE_CLKS  = 4,
  parameter int HOLD_CLKS    = 2,
  parameter int TIMEOUT_CLKS = 255
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_rw,
  input  logic        req_io,
  input  logic [1:0]  req_be,
  input  logic        req_a12,
  input  logic [15:0] req_wdata,
  input  logic        WAIT,
  input  logic [15:0] DG_in,
  output logic [15:0] DG_out,
  output logic        dg_oe,
  output logic        BALE,
  output logic        IOR,
  output logic        IOW,
  output logic        MEMR,
  output logic        MEMW,
  output logic        SA0,
  output logic        SA12,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        timeout
);

  localparam logic [7:0] c_setup_ld   = 8'(SETUP_CLKS - 1);
  localparam logic [7:0] c_strobe_ld  = 8'(STROBE_CLKS - 1);
  localparam logic [7:0] c_hold_ld    = 8'(HOLD_CLKS - 1);
  localparam logic [7:0] c_timeout_ld = 8'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_stretch;
  logic        r_second;
  logic        r_rw;
  logic        r_io;
  logic [1:0]  r_be;
  logic [7:0]  r_wdata_lo;
  logic [15:0] r_rbuf;
  logic        r_tout;

  logic        w_min_done;
  logic        w_strobe_exit;
  logic        w_tout_exit;
  logic [15:0] w_rsample;

  // Memory cycles may stretch past the minimum while WAIT is low; a WAIT
  // seen high on the final allowed cycle still ends the cycle successfully.
  always_comb begin
    w_min_done  = !r_stretch && (r_cnt == 8'd0);
    w_tout_exit = r_stretch && !WAIT && (r_cnt == 8'd0);
    if (r_io) begin
      w_strobe_exit = w_min_done;
      w_rsample     = SA0 ? {r_rbuf[15:8], DG_in[7:0]} : {DG_in[7:0], r_rbuf[7:0]};
    end else begin
      w_strobe_exit = (w_min_done && WAIT) || (r_stretch && (WAIT || (r_cnt == 8'd0)));
      w_rsample     = {r_be[1] ? DG_in[15:8] : 8'hFF, r_be[0] ? DG_in[7:0] : 8'hFF};
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_stretch  <= 1'b0;
      r_second   <= 1'b0;
      r_rw       <= 1'b0;
      r_io       <= 1'b0;
      r_be       <= 2'b00;
      r_wdata_lo <= 8'h00;
      r_rbuf     <= 16'hFFFF;
      r_tout     <= 1'b0;
      DG_out     <= 16'h0001;
      dg_oe      <= 1'b0;
      BALE       <= 1'b1;
      IOR        <= 1'b1;
      IOW        <= 1'b1;
      MEMR       <= 1'b1;
      MEMW       <= 1'b1;
      SA0        <= 1'b1;
      SA12       <= 1'b1;
      ack        <= 1'b0;
      rdata      <= 16'h0000;
      timeout    <= 1'b0;
    end else begin
      ack     <= 1'b0;
      timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid && (req_be != 2'b00)) begin
            r_state    <= S_ADDR;
            r_cnt      <= c_setup_ld;
            r_rw       <= req_rw;
            r_io       <= req_io;
            r_be       <= req_be;
            r_wdata_lo <= req_wdata[7:0];
            r_second   <= req_io && (req_be == 2'b11);
            r_rbuf     <= 16'hFFFF;
            r_tout     <= 1'b0;
            BALE       <= 1'b0;
            // Even byte goes first, so SA0 follows UDS for every plan.
            SA0        <= ~req_be[1];
            SA12       <= req_io ? 1'b0 : req_a12;
            dg_oe      <= ~req_rw;
            if (req_io)
              DG_out <= {8'hFF, req_be[1] ? req_wdata[15:8] : req_wdata[7:0]};
            else
              DG_out <= req_wdata;
          end
        end

        S_ADDR: begin
          if (r_cnt == 8'd0) begin
            r_state   <= S_STROBE;
            r_cnt     <= c_strobe_ld;
            r_stretch <= 1'b0;
            case ({r_io, r_rw})
              2'b11:   IOR  <= 1'b0;
              2'b10:   IOW  <= 1'b0;
              2'b01:   MEMR <= 1'b0;
              default: MEMW <= 1'b0;
            endcase
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        S_STROBE: begin
          if (w_strobe_exit) begin
            r_state <= S_HOLD;
            r_cnt   <= c_hold_ld;
            r_tout  <= w_tout_exit;
            IOR     <= 1'b1;
            IOW     <= 1'b1;
            MEMR    <= 1'b1;
            MEMW    <= 1'b1;
            if (r_rw)
              r_rbuf <= w_rsample;
          end else if (w_min_done) begin
            r_stretch <= 1'b1;
            r_cnt     <= c_timeout_ld;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        S_HOLD: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else if (r_second && !r_tout) begin
            r_state  <= S_ADDR;
            r_cnt    <= c_setup_ld;
            r_second <= 1'b0;
            SA0      <= 1'b1;
            DG_out   <= {8'hFF, r_wdata_lo};
          end else begin
            r_state  <= S_DONE;
            r_second <= 1'b0;
            ack      <= 1'b1;
            timeout  <= r_tout;
            BALE     <= 1'b1;
            SA0      <= 1'b1;
            SA12     <= 1'b1;
            dg_oe    <= 1'b0;
            DG_out   <= 16'h0001;
            if (r_rw)
              rdata <= r_rbuf;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
